// File: rtl/ita_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// ita_scan_decoder_if : scan bus snoop, readback port and status of the decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ita_scan_decoder_if;
  logic [11:0] sel;
  logic [13:0] segm;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_char;
  logic        frame_valid;
  logic        msg_changed;
  logic        seq_err;
  logic        sel_err;
  logic        glyph_err;
  logic        locked;
  logic [7:0]  frame_count;

  modport master (
    output sel, segm, rd_addr,
    input  rd_char, frame_valid, msg_changed, seq_err, sel_err, glyph_err,
           locked, frame_count
  );

  modport slave (
    input  sel, segm, rd_addr,
    output rd_char, frame_valid, msg_changed, seq_err, sel_err, glyph_err,
           locked, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/ita_scan_decoder.sv
// ---------------------------------------------------------------------------
// ita_scan_decoder : rebuilds 12-char frames from the 14-segment scan bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ita_scan_decoder #(
  parameter int LOCK_FRAMES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ita_scan_decoder_if.slave  bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [0:0] {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  state_t      state;
  logic [11:0] sel_q;
  logic [13:0] segm_q;
  logic [7:0]  wbuf [12];
  logic [7:0]  cbuf [12];
  logic [3:0]  last_idx;
  logic        prev_valid;
  logic        frame_bad;
  logic [3:0]  lock_cnt;
  logic        frame_valid_q;
  logic        msg_changed_q;
  logic        seq_err_q;
  logic        sel_err_q;
  logic        glyph_err_q;
  logic        locked_q;
  logic [7:0]  frame_count_q;

  logic [3:0]  idx;
  logic        one_hot;
  logic [7:0]  ch;
  logic        bad;
  logic        differs;

  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (sel_q[i]) idx = 4'(i);
    end
  end

  assign one_hot = (sel_q != 12'd0) && ((sel_q & (sel_q - 12'd1)) == 12'd0);

  always_comb begin
    bad = 1'b0;
    case (segm_q)
      14'b11101111000000: ch = 8'h41;
      14'b10011100000000: ch = 8'h43;
      14'b10011110000000: ch = 8'h45;
      14'b10111101000000: ch = 8'h47;
      14'b10010000010010: ch = 8'h49;
      14'b01101100100100: ch = 8'h4E;
      14'b10110111000000: ch = 8'h53;
      14'b10000000010010: ch = 8'h54;
      14'b01111100000000: ch = 8'h55;
      14'b00001100001001: ch = 8'h56;
      14'b00000000000000: ch = 8'h20;
      default: begin
        ch  = 8'h3F;
        bad = 1'b1;
      end
    endcase
  end

  // Compare the frame about to be committed (digit 11 merged in) with cbuf
  always_comb begin
    differs = (ch != cbuf[11]);
    for (int i = 0; i < 11; i++) begin
      if (wbuf[i] != cbuf[i]) differs = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q         <= '0;
      segm_q        <= '0;
      state         <= HUNT;
      last_idx      <= '0;
      prev_valid    <= 1'b0;
      frame_bad     <= 1'b0;
      lock_cnt      <= '0;
      frame_valid_q <= 1'b0;
      msg_changed_q <= 1'b0;
      seq_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      glyph_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i < 12; i++) begin
        wbuf[i] <= 8'h20;
        cbuf[i] <= 8'h20;
      end
    end else begin
      sel_q         <= bus.sel;
      segm_q        <= bus.segm;
      frame_valid_q <= 1'b0;
      msg_changed_q <= 1'b0;
      seq_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      glyph_err_q   <= 1'b0;

      if (sel_q != 12'd0) begin
        if (!one_hot) begin
          sel_err_q <= 1'b1;
          state     <= HUNT;
          lock_cnt  <= '0;
          locked_q  <= 1'b0;
        end else begin
          case (state)
            HUNT: begin
              if (idx == 4'd0) begin
                wbuf[0]     <= ch;
                glyph_err_q <= bad;
                frame_bad   <= bad;
                last_idx    <= 4'd0;
                state       <= ASSEMBLE;
              end
            end
            ASSEMBLE: begin
              if (idx == last_idx) begin
                wbuf[idx]   <= ch;
                glyph_err_q <= bad;
                if (bad) frame_bad <= 1'b1;
              end else if (idx == last_idx + 4'd1) begin
                wbuf[idx]   <= ch;
                glyph_err_q <= bad;
                last_idx    <= idx;
                if (bad) frame_bad <= 1'b1;
                if (idx == 4'd11) begin
                  for (int i = 0; i < 11; i++) cbuf[i] <= wbuf[i];
                  cbuf[11]      <= ch;
                  frame_valid_q <= 1'b1;
                  msg_changed_q <= differs || !prev_valid;
                  prev_valid    <= 1'b1;
                  frame_count_q <= frame_count_q + 8'd1;
                  state         <= HUNT;
                  if (frame_bad || bad) begin
                    lock_cnt <= '0;
                    locked_q <= 1'b0;
                  end else if (lock_cnt < LOCK_N) begin
                    lock_cnt <= lock_cnt + 4'd1;
                    locked_q <= (lock_cnt + 4'd1 == LOCK_N);
                  end else begin
                    locked_q <= 1'b1;
                  end
                end
              end else begin
                seq_err_q <= 1'b1;
                lock_cnt  <= '0;
                locked_q  <= 1'b0;
                // A stray digit 0 is the start of a fresh frame, not just noise
                if (idx == 4'd0) begin
                  wbuf[0]     <= ch;
                  glyph_err_q <= bad;
                  frame_bad   <= bad;
                  last_idx    <= 4'd0;
                end else begin
                  state <= HUNT;
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end
  end

  assign bus.rd_char     = (bus.rd_addr < 4'd12) ? cbuf[bus.rd_addr] : 8'h00;
  assign bus.frame_valid = frame_valid_q;
  assign bus.msg_changed = msg_changed_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.glyph_err   = glyph_err_q;
  assign bus.locked      = locked_q;
  assign bus.frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ita_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_ita_scan_decoder : directed scan frames with hand-computed expectations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ita_scan_decoder;

  localparam logic [13:0] G_A  = 14'b11101111000000;
  localparam logic [13:0] G_C  = 14'b10011100000000;
  localparam logic [13:0] G_E  = 14'b10011110000000;
  localparam logic [13:0] G_G  = 14'b10111101000000;
  localparam logic [13:0] G_I  = 14'b10010000010010;
  localparam logic [13:0] G_N  = 14'b01101100100100;
  localparam logic [13:0] G_S  = 14'b10110111000000;
  localparam logic [13:0] G_T  = 14'b10000000010010;
  localparam logic [13:0] G_U  = 14'b01111100000000;
  localparam logic [13:0] G_V  = 14'b00001100001001;
  localparam logic [13:0] G_SP = 14'b00000000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [13:0] msg [12];

  int n_fv, n_mc, n_seq, n_sel, n_glyph;
  int fv_cyc, fv_gap, last_lat, d11_cyc, last_drive, seq_cyc, d6;
  logic [7:0] lock_hist;

  ita_scan_decoder_if bus();

  ita_scan_decoder #(.LOCK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_valid) begin
        n_fv++;
        fv_gap    = cyc - fv_cyc;
        fv_cyc    = cyc;
        last_lat  = cyc - d11_cyc;
        lock_hist = {lock_hist[6:0], bus.locked};
      end
      if (bus.msg_changed) n_mc++;
      if (bus.seq_err) begin
        n_seq++;
        seq_cyc = cyc;
      end
      if (bus.sel_err) n_sel++;
      if (bus.glyph_err) n_glyph++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [11:0] s, input logic [13:0] g, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.sel  = s;
      bus.segm = g;
      if (k == 0) last_drive = cyc;
      if (s[11]) d11_cyc = cyc;
    end
  endtask

  // skip < 0 / bad < 0 disable the fault; first..11 are the digits sent
  task automatic frame(input int hold, input int first, input int skip, input int bad);
    logic [11:0] one;
    for (int d = first; d < 12; d++) begin
      if (d != skip) begin
        one = 12'd1 << d;
        put(one, (d == bad) ? 14'h3FFF : msg[d], hold);
        if (d == 6) d6 = last_drive;
      end
    end
  endtask

  task automatic clr();
    @(posedge clk);
    n_fv = 0; n_mc = 0; n_seq = 0; n_sel = 0; n_glyph = 0; lock_hist = '0;
  endtask

  task automatic read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.rd_addr = a;
    #1;
    chk(tag, {24'd0, bus.rd_char}, {24'd0, exp});
  endtask

  initial begin
    msg = '{G_C, G_I, G_N, G_V, G_E, G_S, G_T, G_A, G_V, G_SP, G_G, G_U};
    bus.sel = '0; bus.segm = '0; bus.rd_addr = '0;
    n_fv = 0; n_mc = 0; n_seq = 0; n_sel = 0; n_glyph = 0; lock_hist = '0;
    fv_cyc = 0; fv_gap = 0; last_lat = 0; d11_cyc = 0; last_drive = 0; seq_cyc = 0; d6 = 0;

    #12;
    chk("reset_count", {24'd0, bus.frame_count}, 32'd0);
    chk("reset_locked", {31'd0, bus.locked}, 32'd0);
    read(4'd0, 8'h20, "reset_rd0");
    @(negedge clk);
    rst = 1'b0;

    // 1: three back-to-back frames
    clr();
    for (int f = 0; f < 3; f++) frame(1, 0, -1, -1);
    put(12'd0, 14'd0, 4);
    @(posedge clk);
    chk("t1_frames", n_fv, 3);
    chk("t1_gap", fv_gap, 12);
    chk("t1_latency", last_lat, 2);
    chk("t1_msgchg", n_mc, 1);
    chk("t1_lock_hist", {24'd0, lock_hist}, 32'h03);
    chk("t1_count", {24'd0, bus.frame_count}, 32'd3);
    read(4'd0, 8'h43, "t1_rd0");
    read(4'd9, 8'h20, "t1_rd9");
    read(4'd11, 8'h55, "t1_rd11");
    read(4'd3, 8'h56, "t1_rd3");

    // 2: each digit held 4 clocks
    clr();
    frame(4, 0, -1, -1);
    frame(4, 0, -1, -1);
    put(12'd0, 14'd0, 4);
    @(posedge clk);
    chk("t2_frames", n_fv, 2);
    chk("t2_gap", fv_gap, 48);
    chk("t2_seq", n_seq, 0);
    chk("t2_msgchg", n_mc, 0);
    chk("t2_locked", {31'd0, bus.locked}, 32'd1);

    // 3: digit 5 skipped
    clr();
    frame(1, 0, 5, -1);
    put(12'd0, 14'd0, 4);
    @(posedge clk);
    chk("t3_seq", n_seq, 1);
    chk("t3_seq_lat", seq_cyc - d6, 2);
    chk("t3_nocommit", n_fv, 0);
    chk("t3_unlocked", {31'd0, bus.locked}, 32'd0);
    frame(1, 0, -1, -1);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t3_recommit", n_fv, 1);
    chk("t3_lock1", {31'd0, bus.locked}, 32'd0);
    frame(1, 0, -1, -1);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t3_lock2", {31'd0, bus.locked}, 32'd1);

    // 4: multi-hot sel mid-frame, then digits 5..11 must be ignored
    clr();
    for (int d = 0; d < 5; d++) put(12'd1 << d, msg[d], 1);
    put(12'b000000000011, G_A, 1);
    frame(1, 5, -1, -1);
    put(12'd0, 14'd0, 4);
    @(posedge clk);
    chk("t4_selerr", n_sel, 1);
    chk("t4_seq", n_seq, 0);
    chk("t4_nocommit", n_fv, 0);
    chk("t4_unlocked", {31'd0, bus.locked}, 32'd0);
    frame(1, 0, -1, -1);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t4_recommit", n_fv, 1);

    // 5: unknown glyph on digit 3 (lock counter was 1 here)
    clr();
    frame(1, 0, -1, 3);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t5_glyph", n_glyph, 1);
    chk("t5_commit", n_fv, 1);
    chk("t5_msgchg", n_mc, 1);
    read(4'd3, 8'h3F, "t5_rd3");
    chk("t5_unlocked", {31'd0, bus.locked}, 32'd0);
    frame(1, 0, -1, -1);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t5_good_msgchg", n_mc, 2);
    chk("t5_lock_reset", {31'd0, bus.locked}, 32'd0);
    read(4'd3, 8'h56, "t5_rd3_fixed");

    // 6: asynchronous reset mid-frame
    for (int d = 0; d < 6; d++) put(12'd1 << d, msg[d], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pulses", {26'd0, bus.frame_valid, bus.msg_changed, bus.seq_err,
                      bus.sel_err, bus.glyph_err, bus.locked}, 32'd0);
    chk("t6_count", {24'd0, bus.frame_count}, 32'd0);
    for (int a = 0; a < 12; a++) read(4'(a), 8'h20, "t6_rd_blank");
    read(4'd13, 8'h00, "t6_rd13");
    @(negedge clk);
    rst = 1'b0;
    clr();
    frame(1, 6, -1, -1);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t6_partial_ignored", n_fv, 0);
    frame(1, 0, -1, -1);
    put(12'd0, 14'd0, 3);
    @(posedge clk);
    chk("t6_commit", {24'd0, bus.frame_count}, 32'd1);
    chk("t6_first_msgchg", n_mc, 1);
    read(4'd11, 8'h55, "t6_rd11");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
